// File: rtl/fsk_demod_gen.sv
// FSK tone demodulator: counts synchronized rising edges per fixed window, classifies
// each window as mark/space/idle, debounces the class and tracks carrier presence.
module fsk_demod_gen #(
  parameter int   CNT_W      = 10,
  parameter int   WINDOW     = 16,
  parameter int   HI_THRESH  = 6,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   CONFIRM    = 1,
  parameter int   LOSS_WIN   = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             signal_in,
  output logic             signal_out,
  output logic             bit_valid,
  output logic [CNT_W-1:0] edge_count,
  output logic             carrier_ok
);

  localparam int WCNT_W = $clog2(WINDOW);
  localparam int RUN_W  = $clog2(CONFIRM + 1);
  localparam int IDLE_W = $clog2(LOSS_WIN + 1);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);

  localparam logic [1:0] CLS_IDLE  = 2'd0;
  localparam logic [1:0] CLS_SPACE = 2'd1;
  localparam logic [1:0] CLS_MARK  = 2'd2;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              dly_q, dly_d;
  logic [1:0]        sync_ok_q, sync_ok_d;
  logic              armed_q, armed_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              bit_valid_q, bit_valid_d;
  logic [1:0]        applied_q, applied_d;
  logic [1:0]        cand_q, cand_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [IDLE_W-1:0] idle_run_q, idle_run_d;
  logic              carrier_q, carrier_d;

  logic              rise;
  logic [CNT_W-1:0]  acc_next;
  logic [31:0]       cnt32;
  logic [1:0]        cls;
  logic [RUN_W-1:0]  run_inc;
  logic [IDLE_W-1:0] idle_inc;

  assign rise = sync2_q & ~dly_q;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    sync1_d      = signal_in;
    sync2_d      = sync1_q;
    dly_d        = sync2_q;
    sync_ok_d    = {sync_ok_q[0], 1'b1};
    armed_d      = armed_q;
    wcnt_d       = wcnt_q;
    acc_d        = acc_q;
    edge_count_d = edge_count_q;
    bit_valid_d  = 1'b0;
    applied_d    = applied_q;
    cand_d       = cand_q;
    run_d        = run_q;
    idle_run_d   = idle_run_q;
    carrier_d    = carrier_q;
    run_inc      = '0;
    idle_inc     = idle_run_q;

    acc_next = (rise && !(&acc_q)) ? acc_q + CNT_W'(1) : acc_q;
    cnt32    = 32'(acc_next);
    if (cnt32 == 32'd0)                   cls = CLS_IDLE;
    else if (cnt32 >= $unsigned(HI_THRESH)) cls = CLS_MARK;
    else                                  cls = CLS_SPACE;

    // Synchronizer contents are meaningless until two real samples have shifted in.
    if (!armed_q && sync_ok_q[1] && !sync2_q) armed_d = 1'b1;

    if (armed_q) begin
      if (wcnt_q == WCNT_LAST) begin
        wcnt_d       = '0;
        acc_d        = '0;
        edge_count_d = acc_next;
        bit_valid_d  = 1'b1;

        if (cls == applied_q) begin
          run_d = '0;
        end else begin
          run_inc = (run_q != '0 && cand_q == cls) ? run_q + RUN_W'(1) : RUN_W'(1);
          if (int'(run_inc) >= CONFIRM) begin
            applied_d = cls;
            run_d     = '0;
          end else begin
            run_d  = run_inc;
            cand_d = cls;
          end
        end

        if (cls == CLS_IDLE) begin
          if (int'(idle_run_q) < LOSS_WIN) idle_inc = idle_run_q + IDLE_W'(1);
          idle_run_d = idle_inc;
          if (int'(idle_inc) >= LOSS_WIN) carrier_d = 1'b0;
        end else begin
          idle_run_d = '0;
          carrier_d  = 1'b1;
        end
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        acc_d  = acc_next;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      dly_q        <= 1'b0;
      sync_ok_q    <= 2'b00;
      armed_q      <= 1'b0;
      wcnt_q       <= '0;
      acc_q        <= '0;
      edge_count_q <= '0;
      bit_valid_q  <= 1'b0;
      applied_q    <= CLS_IDLE;
      cand_q       <= CLS_IDLE;
      run_q        <= '0;
      idle_run_q   <= '0;
      carrier_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      dly_q        <= dly_d;
      sync_ok_q    <= sync_ok_d;
      armed_q      <= armed_d;
      wcnt_q       <= wcnt_d;
      acc_q        <= acc_d;
      edge_count_q <= edge_count_d;
      bit_valid_q  <= bit_valid_d;
      applied_q    <= applied_d;
      cand_q       <= cand_d;
      run_q        <= run_d;
      idle_run_q   <= idle_run_d;
      carrier_q    <= carrier_d;
    end
  end

  assign signal_out = (applied_q == CLS_MARK)  ? 1'b1 :
                      (applied_q == CLS_SPACE) ? 1'b0 : IDLE_LEVEL;
  assign bit_valid  = bit_valid_q;
  assign edge_count = edge_count_q;
  assign carrier_ok = carrier_q;

endmodule

// File: doc/fsk_demod_gen.md
# fsk_demod_gen

Parametrised FSK tone demodulator for the FSK link receive path. It samples the line signal in the `sysclk` domain through a synchronizer and counts rising edges over a fixed window of `sysclk` cycles. Each window count is classified as mark, space or idle, debounced across consecutive windows, and driven out as the recovered bit stream. Carrier-detect, a per-window valid strobe and the raw count let downstream framing logic sample bits and track link health.

## Interface
- `CNT_W`, 10: width of the edge counter and of `edge_count`; counts saturate at 2^CNT_W-1.
- `WINDOW`, 16: window length in `sysclk` cycles; must be ≥2.
- `HI_THRESH`, 6: a window count ≥ HI_THRESH classifies as mark (1); 1..HI_THRESH-1 classifies as space (0); 0 classifies as idle.
- `IDLE_LEVEL`, 1: `signal_out` level driven on an idle window.
- `CONFIRM`, 1: number of consecutive windows with the same new class required before `signal_out` changes; must be ≥1.
- `LOSS_WIN`, 4: number of consecutive idle windows that drops `carrier_ok`; must be ≥1.

Ports:
- `sysclk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous reset, active-low.
- `signal_in` in 1: asynchronous FSK line input.
- `signal_out` out 1: recovered bit.
- `bit_valid` out 1: one-cycle strobe; a window classification has just been applied.
- `edge_count` out CNT_W: saturated edge count of the last closed window.
- `carrier_ok` out 1: tone present.

## Operation
- `signal_in` passes through a 2-flop synchronizer, then a delay flop for edge detection. A rising edge is synchronized 1 with delayed 0.
- Arming: the block starts idle (not armed). It arms on the first cycle the synchronized input is 0. No windows run before arming. Arming is cleared only by reset.
- Window counter `wcnt` runs 0..WINDOW-1 while armed, then wraps to 0.
- Edge accumulator increments on each detected edge and saturates at 2^CNT_W-1; it never wraps.
- Window close is the cycle with wcnt==WINDOW-1. An edge detected in the close cycle belongs to the closing window. At close:
  - the final count is latched into `edge_count`;
  - the accumulator clears to 0;
  - the class is computed from the final count.
- Debounce: a run counter tracks consecutive windows whose class differs from the currently applied class.
  - When the run reaches CONFIRM, the class is applied and the run counter clears.
  - A window matching the applied class clears the run.
  - A window of a different third class restarts the run at 1 for that class.
- Applied class drives `signal_out`: mark→1, space→0, idle→IDLE_LEVEL.
- Carrier:
  - `carrier_ok` sets on the first non-idle window; it is not debounced by CONFIRM.
  - An idle-run counter counts consecutive idle windows and saturates at LOSS_WIN.
  - `carrier_ok` clears when the idle run reaches LOSS_WIN.
  - Any non-idle window clears the idle run.
- Reset (reset==0 at a clock edge) forces all outputs to their reset values:
  - `signal_out`=IDLE_LEVEL, `bit_valid`=0, `edge_count`=0, `carrier_ok`=0;
  - synchronizer, accumulator, `wcnt`, run counters and arming are cleared; applied class = idle.
  - Reset asserted mid-window discards that window; no `bit_valid` is produced for it.

## Timing
- Input to edge-detect latency: an edge on `signal_in` is counted 3 `sysclk` edges later.
- Close cycle T: `edge_count` updates at T+1.
- At T+1: `bit_valid`=1 for exactly one cycle; `signal_out` and `carrier_ok` update in the same cycle when their conditions are met.
- `bit_valid` pulses once per window while armed, every WINDOW cycles, whether or not `signal_out` changes.
- With CONFIRM=1, `signal_out` reflects the window ending at T from T+1.
- With CONFIRM=N, a class change is visible N windows after the first differing window.
- Outputs are held between strobes.

## Test plan
- Reset, defaults: hold `signal_in`=1 for 100 cycles → never armed; `bit_valid` stays 0; `signal_out`=1; `carrier_ok`=0; `edge_count`=0.
- Mark tone: `signal_in` toggles every cycle (rising edge every 2 cycles) → each full window gives `edge_count`=8, `signal_out`=1, `carrier_ok`=1; `bit_valid` spaced exactly 16 cycles.
- Space tone: rising edge every 6 cycles → `edge_count` 2 or 3 per window, `signal_out`=0. Switching back to the mark tone → `signal_out`=1 one strobe after the first full mark window.
- Debounce, CONFIRM=2: mark stream with one space window inserted → `signal_out` stays 1. Two consecutive space windows → `signal_out`=0 at the second strobe.
- Carrier loss, LOSS_WIN=4: mark tone, then `signal_in` held 1 → `signal_out`=1 at the first idle strobe. `carrier_ok` drops at the 4th idle strobe, not the 3rd.
- Saturation and mid-window reset:
  - CNT_W=2 with the mark tone → `edge_count`=3.
  - Pull `reset` low at wcnt=7 for 1 cycle → all outputs return to reset values and no strobe occurs. The next window starts only after the input is seen at 0 again.
